// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
//
// Fetch/execute sequencer that sits directly upstream of the instruction
// decoder. It runs the two-cycle fetch (PC -> MAR, RAM -> IR), holds the
// instruction register, presents fetch_complete / step / opcode to the
// decoder, and uses the decoder's steps_required to decide when execution
// ends and the next fetch begins. A wrapping retired-instruction counter is
// kept for debug.
//
// Optional feature macro: SINGLE_STEP_EN
//   Defined   : adds input step_go. After each retired instruction the
//               sequencer parks in HOLD until step_go=1 && run=1.
//   Undefined : no step_go port, EXECUTE returns straight to FETCH_ADDR.
//
// Ports:
//   clk            in   system clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   run            in   1 = advance, 0 = freeze all state
//   bus_in         in   data bus, captured into IR during FETCH_READ
//   steps_required in   execute-step count from decoder (0 behaves as 1)
//   step_go        in   single-step release (SINGLE_STEP_EN only)
//   pc_out_en      out  PC drives bus (FETCH_ADDR)
//   mar_load_fetch out  MAR loads PC (FETCH_ADDR)
//   ram_read_fetch out  RAM drives bus (FETCH_READ)
//   ir_load        out  IR capture strobe (FETCH_READ)
//   fetch_complete out  high throughout EXECUTE
//   step           out  current execute step, 0-based
//   opcode         out  IR[7:4]
//   operand        out  IR[3:0]
//   instr_done     out  one-cycle pulse on the last execute step
//   instr_count    out  retired instructions, wraps
// -----------------------------------------------------------------------------
module control_sequencer #(
    parameter int IR_WIDTH    = 8,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   run,
    input  logic [IR_WIDTH-1:0]    bus_in,
    input  logic [1:0]             steps_required,
`ifdef SINGLE_STEP_EN
    input  logic                   step_go,
`endif
    output logic                   pc_out_en,
    output logic                   mar_load_fetch,
    output logic                   ram_read_fetch,
    output logic                   ir_load,
    output logic                   fetch_complete,
    output logic [1:0]             step,
    output logic [3:0]             opcode,
    output logic [3:0]             operand,
    output logic                   instr_done,
    output logic [COUNT_WIDTH-1:0] instr_count
);

`ifdef SINGLE_STEP_EN
    typedef enum logic [2:0] {
        IDLE,
        FETCH_ADDR,
        FETCH_READ,
        EXECUTE,
        HOLD
    } state_e;
`else
    typedef enum logic [1:0] {
        IDLE,
        FETCH_ADDR,
        FETCH_READ,
        EXECUTE
    } state_e;
`endif

    state_e                 state_q, state_d;
    logic [IR_WIDTH-1:0]    ir_q, ir_d;
    logic [1:0]             step_q, step_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;

    logic [1:0] last_step;
    logic       is_last;

    // steps_required of 0 behaves as 1, so the last step index is never
    // negative. Using >= rather than == means a count that shrinks
    // mid-instruction finishes at once instead of letting step run past it.
    assign last_step = (steps_required == 2'd0) ? 2'd0 : steps_required - 2'd1;
    assign is_last   = (step_q >= last_step);

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ir_q    <= '0;
            step_q  <= 2'd0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            step_q  <= step_d;
            count_q <= count_d;
        end
    end

    // Next-state logic. With run=0 every register simply holds.
    always_comb begin
        // NOTE: every signal gets a hold/default value first so no path
        // through the case leaves it unassigned (which would infer a latch).
        state_d = state_q;
        ir_d    = ir_q;
        step_d  = step_q;
        count_d = count_q;

        if (run) begin
            case (state_q)
                IDLE: begin
                    state_d = FETCH_ADDR;
                end
                FETCH_ADDR: begin
                    state_d = FETCH_READ;
                end
                FETCH_READ: begin
                    ir_d    = bus_in;
                    step_d  = 2'd0;
                    state_d = EXECUTE;
                end
                EXECUTE: begin
                    if (is_last) begin
                        step_d  = 2'd0;
                        count_d = count_q + COUNT_WIDTH'(1);
`ifdef SINGLE_STEP_EN
                        state_d = HOLD;
`else
                        state_d = FETCH_ADDR;
`endif
                    end else begin
                        step_d = step_q + 2'd1;
                    end
                end
`ifdef SINGLE_STEP_EN
                HOLD: begin
                    if (step_go) begin
                        state_d = FETCH_ADDR;
                    end
                end
`endif
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Moore strobes: pure decodes of the registered state.
    assign pc_out_en      = (state_q == FETCH_ADDR);
    assign mar_load_fetch = (state_q == FETCH_ADDR);
    assign ram_read_fetch = (state_q == FETCH_READ);
    assign ir_load        = (state_q == FETCH_READ);
    assign fetch_complete = (state_q == EXECUTE);

    // The retire pulse is gated by run so a frozen last step does not
    // report a completion that is not actually happening.
    assign instr_done     = run && (state_q == EXECUTE) && is_last;

    assign step           = step_q;
    assign opcode         = ir_q[7:4];
    assign operand        = ir_q[3:0];
    assign instr_count    = count_q;

endmodule

// File: tb/tb_control_sequencer.sv
// -----------------------------------------------------------------------------
// tb_control_sequencer
//
// Directed self-checking bench for control_sequencer (default build).
// Inputs change 1 ns after a rising edge; outputs are sampled at that point
// too, well away from the next active edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_control_sequencer;

    logic       clk;
    logic       rst_n;
    logic       run;
    logic [7:0] bus_in;
    logic [1:0] steps_required;
`ifdef SINGLE_STEP_EN
    logic       step_go;
`endif
    logic       pc_out_en;
    logic       mar_load_fetch;
    logic       ram_read_fetch;
    logic       ir_load;
    logic       fetch_complete;
    logic [1:0] step;
    logic [3:0] opcode;
    logic [3:0] operand;
    logic       instr_done;
    logic [7:0] instr_count;

    int errors = 0;
    int checks = 0;

    control_sequencer #(
        .IR_WIDTH    (8),
        .COUNT_WIDTH (8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .run            (run),
        .bus_in         (bus_in),
        .steps_required (steps_required),
`ifdef SINGLE_STEP_EN
        .step_go        (step_go),
`endif
        .pc_out_en      (pc_out_en),
        .mar_load_fetch (mar_load_fetch),
        .ram_read_fetch (ram_read_fetch),
        .ir_load        (ir_load),
        .fetch_complete (fetch_complete),
        .step           (step),
        .opcode         (opcode),
        .operand        (operand),
        .instr_done     (instr_done),
        .instr_count    (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Packed view of the strobes: {pc_out_en, mar_load_fetch, ram_read_fetch, ir_load, fetch_complete}
    function automatic logic [4:0] strobes();
        return {pc_out_en, mar_load_fetch, ram_read_fetch, ir_load, fetch_complete};
    endfunction

    localparam logic [4:0] S_IDLE = 5'b00000;
    localparam logic [4:0] S_FA   = 5'b11000;
    localparam logic [4:0] S_FR   = 5'b00110;
    localparam logic [4:0] S_EX   = 5'b00001;

    initial begin
        rst_n          = 1'b0;
        run            = 1'b0;
        bus_in         = 8'h00;
        steps_required = 2'd0;
`ifdef SINGLE_STEP_EN
        step_go        = 1'b0;
`endif
        #2;
        check("reset_strobes", strobes(), S_IDLE);
        check("reset_ir", {opcode, operand}, 8'h00);
        check("reset_step", step, 2'd0);
        check("reset_count", instr_count, 8'd0);
        check("reset_done", instr_done, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;

        // ---- 2-step instruction 0x1A: 4-cycle loop ----
        run = 1'b1; bus_in = 8'h1A; steps_required = 2'd2;
        check("idle_strobes", strobes(), S_IDLE);
        tick(); check("i1_fa", strobes(), S_FA);
        tick(); check("i1_fr", strobes(), S_FR);
                check("i1_fr_ir_old", {opcode, operand}, 8'h00);
        tick(); check("i1_ex0", strobes(), S_EX);
                check("i1_ex0_step", step, 2'd0);
                check("i1_ex0_done", instr_done, 1'b0);
                check("i1_opcode", opcode, 4'h1);
                check("i1_operand", operand, 4'hA);
        tick(); check("i1_ex1_step", step, 2'd1);
                check("i1_ex1_done", instr_done, 1'b1);
                check("i1_ex1_count", instr_count, 8'd0);
        tick(); check("i1_next_fa", strobes(), S_FA);
                check("i1_count", instr_count, 8'd1);
                check("i1_ir_hold", {opcode, operand}, 8'h1A);

        // ---- 3-step instruction 0x35: 5-cycle loop ----
        bus_in = 8'h35; steps_required = 2'd3;
        tick(); check("i2_fr", strobes(), S_FR);
        tick(); check("i2_ex0", {strobes(), step, instr_done}, {S_EX, 2'd0, 1'b0});
                check("i2_ir", {opcode, operand}, 8'h35);
        tick(); check("i2_ex1", {strobes(), step, instr_done}, {S_EX, 2'd1, 1'b0});
        tick(); check("i2_ex2", {strobes(), step, instr_done}, {S_EX, 2'd2, 1'b1});
        tick(); check("i2_next_fa", strobes(), S_FA);
                check("i2_count", instr_count, 8'd2);

        // ---- steps_required = 0 then 1: 3-cycle NOP loop ----
        bus_in = 8'h7C; steps_required = 2'd0;
        tick(); check("i3_fr", strobes(), S_FR);
        tick(); check("i3_ex0", {strobes(), step, instr_done}, {S_EX, 2'd0, 1'b1});
        tick(); check("i3_next_fa", strobes(), S_FA);
                check("i3_count", instr_count, 8'd3);
        bus_in = 8'hC4; steps_required = 2'd1;
        tick(); check("i4_fr", strobes(), S_FR);
        tick(); check("i4_ex0", {strobes(), step, instr_done}, {S_EX, 2'd0, 1'b1});
                check("i4_ir", {opcode, operand}, 8'hC4);
        tick(); check("i4_next_fa", strobes(), S_FA);
                check("i4_count", instr_count, 8'd4);

        // ---- freeze with run=0 at step1 of a 3-step instruction ----
        bus_in = 8'h9E; steps_required = 2'd3;
        tick(); tick(); tick();
        check("i5_ex1_before_freeze", {strobes(), step}, {S_EX, 2'd1});
        run = 1'b0; bus_in = 8'h00;
        for (int i = 0; i < 4; i++) begin
            #0;
            check("freeze_done", instr_done, 1'b0);
            tick();
            check("freeze_state", {strobes(), step}, {S_EX, 2'd1});
            check("freeze_ir", {opcode, operand}, 8'h9E);
        end
        run = 1'b1;
        #0 check("resume_ex1_done", instr_done, 1'b0);
        tick(); check("resume_ex2", {strobes(), step, instr_done}, {S_EX, 2'd2, 1'b1});
        tick(); check("i5_next_fa", strobes(), S_FA);
                check("i5_count", instr_count, 8'd5);

        // ---- steps_required drops mid-instruction: finish at once ----
        bus_in = 8'h21; steps_required = 2'd3;
        tick(); tick(); tick();
        check("i6_ex1", step, 2'd1);
        steps_required = 2'd1;
        #0 check("i6_drop_done", instr_done, 1'b1);
        tick(); check("i6_next_fa", {strobes(), step}, {S_FA, 2'd0});
                check("i6_count", instr_count, 8'd6);

        // ---- async reset mid-EXECUTE step1 ----
        bus_in = 8'h5B; steps_required = 2'd2;
        tick(); tick(); tick();
        check("i7_ex1", {strobes(), step}, {S_EX, 2'd1});
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_strobes", {strobes(), instr_done}, 6'b0);
        check("rst_mid_outputs", {step, opcode, operand, instr_count}, 18'd0);
        rst_n = 1'b1;
        tick(); check("restart_fa", strobes(), S_FA);
                check("restart_count", instr_count, 8'd0);

        // ---- 256 NOPs: counter wraps 255 -> 0 ----
        steps_required = 2'd1; bus_in = 8'h00;
        for (int n = 0; n < 255; n++) begin
            tick(); tick(); tick();
        end
        check("wrap_255", instr_count, 8'd255);
        check("wrap_fa", strobes(), S_FA);
        tick(); tick();
        check("wrap_last_done", instr_done, 1'b1);
        tick();
        check("wrap_0", instr_count, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
Fetch/execute sequencer directly upstream of the instruction decoder. It runs the two-cycle fetch (PC→MAR, RAM→IR), holds the instruction register, and drives fetch_complete, step and opcode into the decoder. It consumes the decoder's steps_required to decide when execution ends and the next fetch begins. It also keeps a retired-instruction counter for debug.

Parameters:
IR_WIDTH, 8, instruction register width; opcode = IR[7:4], operand = IR[3:0]
COUNT_WIDTH, 8, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
run  in  1  1 = sequencer advances; 0 = freeze all state
bus_in  in  IR_WIDTH  data bus; IR samples it in FETCH_READ
steps_required  in  2  execute-step count from decoder; 0 is treated as 1
pc_out_en  out  1  PC drives bus / MAR (FETCH_ADDR)
mar_load_fetch  out  1  MAR loads PC (FETCH_ADDR)
ram_read_fetch  out  1  RAM drives bus (FETCH_READ)
ir_load  out  1  IR capture strobe (FETCH_READ)
fetch_complete  out  1  high throughout EXECUTE
step  out  2  current execute step, 0-based
opcode  out  4  IR[7:4]
operand  out  4  IR[3:0]
instr_done  out  1  one-cycle pulse on the last execute step
instr_count  out  COUNT_WIDTH  retired instructions, wraps

Behaviour:
- States: IDLE, FETCH_ADDR, FETCH_READ, EXECUTE. Registered 2-bit state. Strobes are Moore decodes of state. instr_done is decoded from EXECUTE && last step.
- Async reset (rst_n=0): state=IDLE, IR=0, step=0, instr_count=0. Every output is 0 during and right after reset: opcode=0, operand=0, fetch_complete=0.
- IDLE: no strobes. If run=1, go to FETCH_ADDR on the next edge.
- FETCH_ADDR: pc_out_en=mar_load_fetch=1. Next state is FETCH_READ.
- FETCH_READ: ram_read_fetch=ir_load=1. IR<=bus_in on the closing edge. step<=0. Next state is EXECUTE.
- EXECUTE: fetch_complete=1. Let last = max(steps_required,1)-1.
  - If step==last: instr_done=1. On the edge: step<=0, instr_count<=instr_count+1 (wraps to 0 after all ones), state<=FETCH_ADDR.
  - Otherwise step<=step+1.
- steps_required is sampled every cycle, because the decoder may change it per step (conditional jumps).
- If step>last (steps_required dropped mid-instruction), treat it as the last step: finish immediately, step never wraps past 3.
- IR holds its value through EXECUTE and the next FETCH_ADDR. It changes only on ir_load.
- run=0 in any state: state, step, IR and counter hold. Moore strobes stay at their state's values. The instr_done pulse is suppressed while run=0. Asserting run resumes exactly where the sequencer stopped.
- Latency: an instruction with N steps takes 2+N cycles, fetch to fetch. NOP (N=1) takes 3 cycles.
- Reset mid-EXECUTE or mid-fetch: immediate return to IDLE. The partial instruction is not counted.

Optional Feature:
SINGLE_STEP_EN: adds input step_go (1 bit).
- Defined: after instr_done, the sequencer enters a HOLD state with all strobes 0 and fetch_complete=0. It leaves HOLD for FETCH_ADDR on the first cycle step_go=1 && run=1. step_go is level-sampled, and the user supplies one-cycle pulses.
- Not defined: no port and no HOLD state. EXECUTE goes straight to FETCH_ADDR.

Test Plan:
- Reset, then run=1, bus_in=0x1A, steps_required=2 → IDLE, FETCH_ADDR, FETCH_READ, EXECUTE step0, step1 (instr_done=1), FETCH_ADDR. opcode=1, operand=A, instr_count=1; loop period is 4 cycles.
- steps_required=3, bus_in=0x35 → step 0,1,2 with fetch_complete=1 for 3 cycles; instr_done on step 2; 5-cycle period.
- steps_required=0 (and 1) → single execute cycle with instr_done=1; 3-cycle period; step stays 0.
- In EXECUTE step1 of a 3-step instruction, drop run for 4 cycles → step, state and IR frozen with no instr_done; after run=1 the sequence resumes at step1 and completes.
- Pulse rst_n low mid-EXECUTE step1 → all outputs 0 asynchronously; instr_count=0; restart from IDLE.
- Run 256 NOPs (steps_required=1) → instr_count wraps 255→0. With SINGLE_STEP_EN defined, no second FETCH_ADDR occurs until step_go is pulsed.
